// File: rtl/tinyalu_param_if.sv
// Request/response bundle for tinyalu_param: operands, opcode, start/ready
// handshake and the done/err/result return path.
interface tinyalu_param_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2:0]         op;
    logic               start;
    logic               ready;
    logic               done;
    logic               err;
    logic [2*WIDTH-1:0] result;

    modport master (
        output A, B, op, start,
        input  ready, done, err, result
    );

    modport slave (
        input  A, B, op, start,
        output ready, done, err, result
    );
endinterface

// File: rtl/tinyalu_param.sv
// WIDTH-bit ALU: single-cycle add/and/xor/sub, MULT_STAGES-deep multiply,
// start/ready handshake with operand capture at accept and illegal-opcode flag.
module tinyalu_param #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned MULT_STAGES = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    tinyalu_param_if.slave bus
);
    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(MULT_STAGES);
    localparam logic [CW-1:0] LAST_STAGE = CW'(MULT_STAGES - 1);

    typedef enum logic {
        IDLE,
        MBUSY
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_AND  = 3'b010,
        OP_XOR  = 3'b011,
        OP_MUL  = 3'b100,
        OP_SUB  = 3'b101,
        OP_ILL6 = 3'b110,
        OP_ILL7 = 3'b111
    } op_t;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  stage_cnt;
    logic [RW-1:0]  pipe [MULT_STAGES];

    logic [RW-1:0]  a_ext;
    logic [RW-1:0]  b_ext;
    logic [RW-1:0]  alu_value;
    logic           is_single;
    logic           is_mul;
    logic           is_illegal;
    logic           ready;
    logic           mul_finish;
    logic           accept;

    logic           done_q;
    logic           err_q;
    logic [RW-1:0]  result_q;

    always_comb begin
        a_ext = {{WIDTH{1'b0}}, bus.A};
        b_ext = {{WIDTH{1'b0}}, bus.B};
    end

    always_comb begin
        is_single  = 1'b0;
        is_mul     = 1'b0;
        is_illegal = 1'b0;
        alu_value  = '0;
        case (op_t'(bus.op))
            OP_ADD: begin
                is_single = 1'b1;
                alu_value = a_ext + b_ext;
            end
            OP_AND: begin
                is_single = 1'b1;
                alu_value = a_ext & b_ext;
            end
            OP_XOR: begin
                is_single = 1'b1;
                alu_value = a_ext ^ b_ext;
            end
            OP_SUB: begin
                is_single = 1'b1;
                alu_value = a_ext - b_ext;
            end
            OP_MUL:          is_mul     = 1'b1;
            OP_ILL6, OP_ILL7: is_illegal = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && is_mul) state_next = MBUSY;
            MBUSY:   if (stage_cnt == LAST_STAGE) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready      = (state == IDLE);
        mul_finish = (state == MBUSY) && (stage_cnt == LAST_STAGE);
        accept     = bus.start && ready;
    end

    // Product is formed at accept and walks a register chain so retiming can
    // spread the multiplier; pipe[MULT_STAGES-1] is valid on the finishing edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stage_cnt <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            result_q  <= '0;
            for (int unsigned i = 0; i < MULT_STAGES; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            for (int unsigned i = 1; i < MULT_STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
            if (accept && is_mul) begin
                pipe[0]   <= a_ext * b_ext;
                stage_cnt <= '0;
            end else if (state == MBUSY && !mul_finish) begin
                stage_cnt <= stage_cnt + 1'b1;
            end

            if (mul_finish) begin
                result_q <= pipe[MULT_STAGES-1];
                err_q    <= 1'b0;
                done_q   <= 1'b1;
            end else if (accept && is_single) begin
                result_q <= alu_value;
                err_q    <= 1'b0;
                done_q   <= 1'b1;
            end else if (accept && is_illegal) begin
                err_q  <= 1'b1;
                done_q <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.ready  = ready;
        bus.done   = done_q;
        bus.err    = err_q;
        bus.result = result_q;
    end
endmodule

// File: tb/tb_tinyalu_param.sv
// Bench for tinyalu_param: directed scenarios on WIDTH=8/MULT_STAGES=3 and
// WIDTH=16/MULT_STAGES=5, plus randomized traffic against an arithmetic model.
module tb_tinyalu_param;
    logic clk = 1'b0;
    logic rst8;
    logic rst16;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    tinyalu_param_if #(.WIDTH(8))  bus8 ();
    tinyalu_param_if #(.WIDTH(16)) bus16 ();

    tinyalu_param #(.WIDTH(8), .MULT_STAGES(3)) u_alu8 (
        .clk     (clk),
        .reset_n (rst8),
        .bus     (bus8)
    );

    tinyalu_param #(.WIDTH(16), .MULT_STAGES(5)) u_alu16 (
        .clk     (clk),
        .reset_n (rst16),
        .bus     (bus16)
    );

    // Reference: plain arithmetic on the zero-extended operands, modulo 2^(2w).
    function automatic logic [31:0] ref_calc(input logic [2:0] op, input longint a,
                                              input longint b, input int w);
        longint m;
        m = (longint'(1) << (2 * w)) - 1;
        case (op)
            3'd1:    return 32'((a + b) & m);
            3'd2:    return 32'(a & b);
            3'd3:    return 32'(a ^ b);
            3'd4:    return 32'((a * b) & m);
            3'd5:    return 32'((a - b) & m);
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic st);
        bus8.op    = op;
        bus8.A     = a;
        bus8.B     = b;
        bus8.start = st;
    endtask

    task automatic test_reset();
        rst8  = 1'b0;
        rst16 = 1'b0;
        drive8(3'd1, 8'h11, 8'h22, 1'b1);
        tick();
        tick();
        checks++; if (bus8.ready !== 1'b1) begin errors++; $display("FAIL reset_ready8: got %b expected 1", bus8.ready); end
        checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL reset_done8: got %b expected 0", bus8.done); end
        checks++; if (bus8.err !== 1'b0) begin errors++; $display("FAIL reset_err8: got %b expected 0", bus8.err); end
        checks++; if (bus8.result !== 16'h0000) begin errors++; $display("FAIL reset_result8: got %h expected 0000", bus8.result); end
        checks++; if (bus16.ready !== 1'b1) begin errors++; $display("FAIL reset_ready16: got %b expected 1", bus16.ready); end
        checks++; if (bus16.result !== 32'h0) begin errors++; $display("FAIL reset_result16: got %h expected 0", bus16.result); end
        drive8(3'd0, 8'h00, 8'h00, 1'b0);
        rst8  = 1'b1;
        rst16 = 1'b1;
        tick();
    endtask

    task automatic test_add();
        drive8(3'd1, 8'hFF, 8'h01, 1'b1);
        tick();
        drive8(3'd0, 8'h00, 8'h00, 1'b0);
        checks++; if (bus8.done !== 1'b1) begin errors++; $display("FAIL add_done: got %b expected 1", bus8.done); end
        checks++; if (bus8.result !== 16'h0100) begin errors++; $display("FAIL add_result: got %h expected 0100", bus8.result); end
        checks++; if (bus8.err !== 1'b0) begin errors++; $display("FAIL add_err: got %b expected 0", bus8.err); end
        checks++; if (bus8.ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b expected 1", bus8.ready); end
        tick();
        checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got %b expected 0", bus8.done); end
        checks++; if (bus8.result !== 16'h0100) begin errors++; $display("FAIL add_hold: got %h expected 0100", bus8.result); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops  [3] = '{3'd2, 3'd3, 3'd5};
        logic [7:0]  as   [3] = '{8'hF0, 8'hF0, 8'h03};
        logic [7:0]  bs   [3] = '{8'h3C, 8'h3C, 8'h05};
        logic [15:0] exps [3] = '{16'h0030, 16'h00CC, 16'hFFFE};
        for (int i = 0; i < 3; i++) begin
            drive8(ops[i], as[i], bs[i], 1'b1);
            tick();
            checks++; if (bus8.done !== 1'b1) begin errors++; $display("FAIL b2b_done[%0d]: got %b expected 1", i, bus8.done); end
            checks++; if (bus8.result !== exps[i]) begin errors++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, bus8.result, exps[i]); end
        end
        drive8(3'd0, 8'h00, 8'h00, 1'b0);
        tick();
        checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL b2b_idle_done: got %b expected 0", bus8.done); end
    endtask

    task automatic test_mul_busy();
        drive8(3'd4, 8'hFF, 8'hFF, 1'b1);
        tick();
        for (int c = 0; c < 3; c++) begin
            checks++; if (bus8.ready !== 1'b0) begin errors++; $display("FAIL mul_busy_ready[%0d]: got %b expected 0", c, bus8.ready); end
            checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL mul_busy_done[%0d]: got %b expected 0", c, bus8.done); end
            drive8(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b1);
            tick();
        end
        drive8(3'd0, 8'h00, 8'h00, 1'b0);
        checks++; if (bus8.done !== 1'b1) begin errors++; $display("FAIL mul_done: got %b expected 1", bus8.done); end
        checks++; if (bus8.result !== 16'hFE01) begin errors++; $display("FAIL mul_result: got %h expected fe01", bus8.result); end
        checks++; if (bus8.ready !== 1'b1) begin errors++; $display("FAIL mul_ready_at_done: got %b expected 1", bus8.ready); end
        checks++; if (bus8.err !== 1'b0) begin errors++; $display("FAIL mul_err: got %b expected 0", bus8.err); end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL mul_dropped_start[%0d]: got done %b expected 0", c, bus8.done); end
        end
        checks++; if (bus8.result !== 16'hFE01) begin errors++; $display("FAIL mul_hold: got %h expected fe01", bus8.result); end
    endtask

    task automatic test_illegal();
        drive8(3'd1, 8'd2, 8'd3, 1'b1);
        tick();
        checks++; if (bus8.result !== 16'h0005) begin errors++; $display("FAIL ill_pre_result: got %h expected 0005", bus8.result); end
        drive8(3'd6, 8'hAA, 8'h55, 1'b1);
        tick();
        checks++; if (bus8.done !== 1'b1) begin errors++; $display("FAIL ill_done: got %b expected 1", bus8.done); end
        checks++; if (bus8.err !== 1'b1) begin errors++; $display("FAIL ill_err: got %b expected 1", bus8.err); end
        checks++; if (bus8.result !== 16'h0005) begin errors++; $display("FAIL ill_result_held: got %h expected 0005", bus8.result); end
        drive8(3'd1, 8'd2, 8'd2, 1'b1);
        tick();
        drive8(3'd0, 8'h00, 8'h00, 1'b0);
        checks++; if (bus8.err !== 1'b0) begin errors++; $display("FAIL ill_err_clear: got %b expected 0", bus8.err); end
        checks++; if (bus8.result !== 16'h0004) begin errors++; $display("FAIL ill_post_result: got %h expected 0004", bus8.result); end
        tick();
    endtask

    task automatic test_reset_mid_mul();
        drive8(3'd4, 8'd7, 8'd9, 1'b1);
        tick();
        drive8(3'd1, 8'd1, 8'd1, 1'b1);
        rst8 = 1'b0;
        tick();
        rst8 = 1'b1;
        drive8(3'd0, 8'h00, 8'h00, 1'b0);
        checks++; if (bus8.ready !== 1'b1) begin errors++; $display("FAIL rmm_ready: got %b expected 1", bus8.ready); end
        checks++; if (bus8.result !== 16'h0000) begin errors++; $display("FAIL rmm_result: got %h expected 0000", bus8.result); end
        for (int c = 0; c < 6; c++) begin
            checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL rmm_no_done[%0d]: got %b expected 0", c, bus8.done); end
            tick();
        end
        drive8(3'd1, 8'd1, 8'd1, 1'b1);
        tick();
        drive8(3'd0, 8'h00, 8'h00, 1'b0);
        checks++; if (bus8.done !== 1'b1) begin errors++; $display("FAIL rmm_add_done: got %b expected 1", bus8.done); end
        checks++; if (bus8.result !== 16'h0002) begin errors++; $display("FAIL rmm_add_result: got %h expected 0002", bus8.result); end
        tick();
    endtask

    task automatic test_random();
        int          mul_left = 0;
        logic [15:0] pending  = '0;
        logic [15:0] exp_res  = '0;
        logic        exp_err  = 1'b0;
        logic        exp_done;
        logic        accepted;
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        st;
        rst8 = 1'b0;
        drive8(3'd0, 8'h00, 8'h00, 1'b0);
        tick();
        rst8 = 1'b1;
        for (int n = 0; n < 400; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = 8'($urandom);
            st = ($urandom_range(0, 3) != 0);
            drive8(op, a, b, st);
            accepted = st && (mul_left == 0);
            tick();
            exp_done = 1'b0;
            if (mul_left > 0) begin
                mul_left--;
                if (mul_left == 0) begin
                    exp_done = 1'b1;
                    exp_res  = pending;
                    exp_err  = 1'b0;
                end
            end else if (accepted) begin
                case (op)
                    3'd0: ;
                    3'd4: begin
                        mul_left = 3;
                        pending  = 16'(ref_calc(op, longint'(a), longint'(b), 8));
                    end
                    3'd6, 3'd7: begin
                        exp_done = 1'b1;
                        exp_err  = 1'b1;
                    end
                    default: begin
                        exp_done = 1'b1;
                        exp_res  = 16'(ref_calc(op, longint'(a), longint'(b), 8));
                        exp_err  = 1'b0;
                    end
                endcase
            end
            checks++; if (bus8.ready !== (mul_left == 0)) begin errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", n, bus8.ready, (mul_left == 0)); end
            checks++; if (bus8.done !== exp_done) begin errors++; $display("FAIL rnd_done[%0d]: got %b expected %b", n, bus8.done, exp_done); end
            checks++; if (bus8.result !== exp_res) begin errors++; $display("FAIL rnd_result[%0d]: got %h expected %h", n, bus8.result, exp_res); end
            checks++; if (bus8.err !== exp_err) begin errors++; $display("FAIL rnd_err[%0d]: got %b expected %b", n, bus8.err, exp_err); end
        end
        drive8(3'd0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_width16();
        logic [31:0] exp_prod;
        exp_prod = ref_calc(3'd4, longint'(16'hFFFF), longint'(16'hFFFF), 16);
        bus16.op = 3'd4; bus16.A = 16'hFFFF; bus16.B = 16'hFFFF; bus16.start = 1'b1;
        tick();
        bus16.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus16.done !== 1'b0) begin errors++; $display("FAIL w16_early_done[%0d]: got %b expected 0", k, bus16.done); end
            checks++; if (bus16.ready !== 1'b0) begin errors++; $display("FAIL w16_busy_ready[%0d]: got %b expected 0", k, bus16.ready); end
            tick();
        end
        checks++; if (bus16.done !== 1'b0) begin errors++; $display("FAIL w16_done_at4: got %b expected 0", bus16.done); end
        tick();
        checks++; if (bus16.done !== 1'b1) begin errors++; $display("FAIL w16_done_at5: got %b expected 1", bus16.done); end
        checks++; if (bus16.result !== exp_prod) begin errors++; $display("FAIL w16_result: got %h expected %h", bus16.result, exp_prod); end
        checks++; if (bus16.ready !== 1'b1) begin errors++; $display("FAIL w16_ready: got %b expected 1", bus16.ready); end
        bus16.op = 3'd0; bus16.A = 16'h1234; bus16.B = 16'h5678; bus16.start = 1'b1;
        tick();
        bus16.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus16.done !== 1'b0) begin errors++; $display("FAIL w16_nop_done[%0d]: got %b expected 0", k, bus16.done); end
            tick();
        end
        checks++; if (bus16.result !== 32'hFFFE0001) begin errors++; $display("FAIL w16_nop_hold: got %h expected fffe0001", bus16.result); end
    endtask

    initial begin
        bus8.op = 3'd0;  bus8.A = '0;  bus8.B = '0;  bus8.start = 1'b0;
        bus16.op = 3'd0; bus16.A = '0; bus16.B = '0; bus16.start = 1'b0;
        rst8  = 1'b0;
        rst16 = 1'b0;
        test_reset();
        test_add();
        test_back_to_back();
        test_mul_busy();
        test_illegal();
        test_reset_mid_mul();
        test_random();
        test_width16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
